// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: shifts accepted bits into a PAT_W window and pulses
// match (one cycle later) when the full window equals the loaded pattern.
module seq_pattern_detector #(
    parameter int             PAT_W       = 5,
    parameter int             CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 5'b10110,
    parameter logic           DEFAULT_OVL = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_bit,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic                         cfg_overlap,
    input  logic                         clr_count,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(PAT_W+1)-1:0]   fill,
    output logic                         armed
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {FILL, ARMED} state_t;

    state_t           state;
    logic [PAT_W-1:0] pattern_r;
    logic             overlap_r;
    logic [PAT_W-1:0] window;

    logic [PAT_W-1:0] shifted;
    logic [FW-1:0]    fill_next;
    logic             accept;
    logic             hit;

    // Window/fill as they would be after taking in_bit; hit only counts on an accepted bit.
    always_comb begin
        shifted   = {window[PAT_W-2:0], in_bit};
        fill_next = (state == ARMED) ? FILL_FULL : fill + FW'(1);
        accept    = in_valid && !cfg_load;
        hit       = accept && (fill_next == FILL_FULL) && (shifted == pattern_r);
    end

    assign armed = (state == ARMED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_r   <= DEFAULT_PAT;
            overlap_r   <= DEFAULT_OVL;
            window      <= '0;
            fill        <= '0;
            state       <= FILL;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= hit;

            // Clear beats a same-edge hit; the count never wraps.
            if (clr_count)
                match_count <= '0;
            else if (hit && match_count != CNT_MAX)
                match_count <= match_count + CNT_W'(1);

            if (cfg_load) begin
                pattern_r <= cfg_pattern;
                overlap_r <= cfg_overlap;
                window    <= '0;
                fill      <= '0;
                state     <= FILL;
            end else if (accept) begin
                if (hit && !overlap_r) begin
                    window <= '0;
                    fill   <= '0;
                    state  <= FILL;
                end else begin
                    window <= shifted;
                    fill   <= fill_next;
                    state  <= (fill_next == FILL_FULL) ? ARMED : FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus random traffic, checked
// against a bit-history reference model through an expected-output queue.
module tb_seq_pattern_detector;

  localparam int PAT_W = 5;
  localparam int CNT_W = 3;
  localparam int FW    = $clog2(PAT_W + 1);
  localparam int OW    = 1 + CNT_W + FW + 1;
  localparam logic [PAT_W-1:0] DEF_PAT = 5'b10110;
  localparam logic             DEF_OVL = 1'b1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic             clr_count;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [FW-1:0]    fill;
  logic             armed;

  seq_pattern_detector #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .DEFAULT_PAT(DEF_PAT), .DEFAULT_OVL(DEF_OVL)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .match(match), .match_count(match_count),
    .fill(fill), .armed(armed)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // reference model: the accepted bits since the last restart, newest last
  logic [PAT_W-1:0] m_pat;
  logic             m_ovl;
  bit               hist[$];
  int               m_cnt;

  function automatic void model_reset();
    m_pat = DEF_PAT;
    m_ovl = DEF_OVL;
    hist.delete();
    m_cnt = 0;
  endfunction

  function automatic bit history_is_pattern();
    if (hist.size() != PAT_W) return 1'b0;
    for (int i = 0; i < PAT_W; i++)
      if (hist[i] != m_pat[PAT_W-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [OW-1:0] model_step(input logic v, input logic b, input logic load,
                                               input logic [PAT_W-1:0] pat, input logic ovl,
                                               input logic clr);
    bit hit;
    logic [CNT_W-1:0] c;
    logic [FW-1:0] f;
    bit a;
    hit = 1'b0;
    if (load) begin
      m_pat = pat;
      m_ovl = ovl;
      hist.delete();
    end else if (v) begin
      hist.push_back(b);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      hit = history_is_pattern();
      if (hit && !m_ovl) hist.delete();
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    c = CNT_W'(m_cnt);
    f = FW'(hist.size());
    a = (hist.size() == PAT_W);
    return {hit, c, f, a};
  endfunction

  // driver
  task automatic drive(input logic v, input logic b, input logic load,
                       input logic [PAT_W-1:0] pat, input logic ovl, input logic clr);
    @(negedge clk);
    in_valid    = v;
    in_bit      = b;
    cfg_load    = load;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    clr_count   = clr;
    exp_q.push_back(model_step(v, b, load, pat, ovl, clr));
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, b, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] pat, input logic ovl);
    drive(1'b0, 1'b0, 1'b1, pat, ovl, 1'b0);
  endtask

  task automatic send_pat(input logic [PAT_W-1:0] p);
    for (int i = PAT_W - 1; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic set_idle_inputs();
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
    clr_count   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({match, match_count, fill, armed} !== '0) begin
      errors++;
      $display("FAIL %s: match=%0b count=%0d fill=%0d armed=%0b, required all zero",
               name, match, match_count, fill, armed);
    end
  endtask

  // asynchronous reset landing between clock edges
  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    set_idle_inputs();
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor: every cycle the DUT presents a full output vector
  logic [OW-1:0] mon_exp;
  logic [OW-1:0] mon_act;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {match, match_count, fill, armed};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL out @%0t: match=%0b/%0b count=%0d/%0d fill=%0d/%0d armed=%0b/%0b (actual/required)",
                 $time, mon_act[OW-1], mon_exp[OW-1],
                 mon_act[OW-2 -: CNT_W], mon_exp[OW-2 -: CNT_W],
                 mon_act[FW:1], mon_exp[FW:1], mon_act[0], mon_exp[0]);
      end
    end
  end

  initial begin
    set_idle_inputs();
    reset = 1'b1;
    model_reset();
    #2;
    check_reset_outputs("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // default pattern, back-to-back bits
    send_pat(DEF_PAT);
    idle(2);

    // overlap then non-overlap on an alternating stream
    load_cfg(5'b10101, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(i % 2 == 0);
    idle(1);
    load_cfg(5'b10101, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(i % 2 == 0);
    idle(1);

    // gaps between valid bits are transparent
    load_cfg(DEF_PAT, 1'b1);
    send_bit(1'b1); send_bit(1'b0);
    idle(3);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    idle(1);

    // saturation, then clear on the same edge as a hit
    load_cfg(5'b11111, 1'b1);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    send_bit(1'b1);
    idle(1);

    // cfg_load wins over a valid bit on the same edge
    load_cfg(DEF_PAT, 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    drive(1'b1, 1'b1, 1'b1, DEF_PAT, 1'b1, 1'b0);
    send_bit(1'b0);
    idle(1);
    send_pat(DEF_PAT);
    idle(1);

    // simultaneous load and clear
    drive(1'b0, 1'b0, 1'b1, DEF_PAT, 1'b0, 1'b1);

    // async reset after 4 of 5 bits
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    async_reset_pulse();
    send_bit(1'b0);
    idle(1);
    send_pat(DEF_PAT);
    idle(1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic v, b, ld, ov, cl;
      logic [PAT_W-1:0] p;
      v  = ($urandom_range(0, 99) < 75);
      b  = $urandom_range(0, 1);
      ld = ($urandom_range(0, 99) < 2);
      ov = $urandom_range(0, 1);
      cl = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0:       p = 5'b11111;
        1:       p = 5'b10101;
        default: p = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
      endcase
      drive(v, b, ld, p, ov, cl);
      if ($urandom_range(0, 999) == 0) async_reset_pulse();
    end

    @(negedge clk);
    set_idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
